// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle processor control FSM.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_JAL, CLS_JR
  } instr_cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [1:0] WB_DM  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_SUM = 2'b10;

  localparam logic [1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP = 2'b10;
  localparam logic [1:0] PC_SRC_RS  = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RT  = 2'b00;
  localparam logic [1:0] ALUB_4   = 2'b01;
  localparam logic [1:0] ALUB_IMM = 2'b10;

  // fetch/branch are state flags; their strobes are qualified by mem_ready/zero at the port.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       fetch;
    logic       branch;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       bus_err;
  } ctrl_t;

  function automatic logic is_alu_funct(input logic [5:0] f);
    case (f)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_decode.sv
// Combinational main decoder: opcode/funct to instruction class plus illegal flag.
module mc_main_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls     = CLS_R;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        if (i_funct == FN_JR)            o_cls = CLS_JR;
        else if (!is_alu_funct(i_funct)) o_illegal = 1'b1;
      end
      OP_ADDI: o_cls = CLS_ADDI;
      OP_LW:   o_cls = CLS_LW;
      OP_SW:   o_cls = CLS_SW;
      OP_BEQ:  o_cls = CLS_BEQ;
      OP_J:    o_cls = CLS_J;
      OP_JAL:  o_cls = CLS_JAL;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback over one memory port,
// with a memory wait timeout that parks the FSM in a sticky error state.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] o_dbg_state
);

  state_t           r_state, w_next;
  instr_cls_t       r_cls, w_dec_cls, w_cls_n;
  logic [2:0]       w_dec_cls_raw;
  logic             w_dec_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic             w_wait, w_timeout;
  ctrl_t            r_ctrl, w_ctrl;
  logic             r_done, r_illegal;

  mc_main_decode u_dec (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_cls     (w_dec_cls_raw),
    .o_illegal (w_dec_illegal)
  );

  assign w_dec_cls = instr_cls_t'(w_dec_cls_raw);
  assign w_wait    = (r_state == FETCH || r_state == MEM) && !mem_ready;
  assign w_timeout = w_wait && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = FETCH;
      FETCH:  if (mem_ready) w_next = DECODE;
              else if (w_timeout) w_next = ERR;
      DECODE: begin
        if (w_dec_illegal) w_next = FETCH;
        else begin
          case (w_dec_cls)
            CLS_BEQ:                w_next = BRANCH;
            CLS_J, CLS_JAL, CLS_JR: w_next = JUMP;
            default:                w_next = EXEC;
          endcase
        end
      end
      EXEC:   w_next = (r_cls == CLS_LW || r_cls == CLS_SW) ? MEM : WB;
      MEM:    if (mem_ready) w_next = (r_cls == CLS_SW) ? FETCH : WB;
              else if (w_timeout) w_next = ERR;
      WB, BRANCH, JUMP: w_next = FETCH;
      ERR:    w_next = ERR;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so the class must be
  // taken straight from the decoder on the DECODE->EXEC transition.
  always_comb begin
    w_ctrl  = '0;
    w_cls_n = (r_state == DECODE) ? w_dec_cls : r_cls;
    case (w_next)
      FETCH: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.fetch     = 1'b1;
        w_ctrl.alu_src_b = ALUB_4;
      end
      EXEC: begin
        if (w_cls_n == CLS_R) w_ctrl.alu_op = ALU_OP_FUNCT;
        else begin
          w_ctrl.alu_op    = ALU_OP_ADD;
          w_ctrl.alu_src_b = ALUB_IMM;
        end
      end
      MEM: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.iord    = 1'b1;
        w_ctrl.mem_we  = (w_cls_n == CLS_SW);
      end
      WB: begin
        w_ctrl.reg_write = 1'b1;
        case (w_cls_n)
          CLS_R:    begin w_ctrl.reg_dst = REG_DST_RD; w_ctrl.wb_sel = WB_ALU; end
          CLS_ADDI: begin w_ctrl.reg_dst = REG_DST_RT; w_ctrl.wb_sel = WB_ALU; end
          default:  begin w_ctrl.reg_dst = REG_DST_RT; w_ctrl.wb_sel = WB_DM;  end
        endcase
      end
      BRANCH: begin
        w_ctrl.alu_op = ALU_OP_SUB;
        w_ctrl.pc_src = PC_SRC_BR;
        w_ctrl.branch = 1'b1;
      end
      JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = (w_cls_n == CLS_JR) ? PC_SRC_RS : PC_SRC_JMP;
        if (w_cls_n == CLS_JAL) begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.reg_dst   = REG_DST_RA;
          w_ctrl.wb_sel    = WB_SUM;
        end
      end
      ERR:     w_ctrl.bus_err = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cls     <= CLS_R;
      r_cnt     <= '0;
      r_ctrl    <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= w_ctrl;
      if (r_state == DECODE) r_cls <= w_dec_cls;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_wait)       r_cnt <= r_cnt + 1'b1;
      r_done    <= (r_state == WB) || (r_state == BRANCH) || (r_state == JUMP) ||
                   ((r_state == MEM) && mem_ready && (r_cls == CLS_SW));
      r_illegal <= (r_state == DECODE) && w_dec_illegal;
    end
  end

  // IR/PC load on the fetch handshake and the beq condition are known only in-cycle.
  assign ir_write    = r_ctrl.fetch & mem_ready;
  assign pc_write    = r_ctrl.pc_write | (r_ctrl.fetch & mem_ready) | (r_ctrl.branch & zero);
  assign mem_req     = r_ctrl.mem_req;
  assign mem_we      = r_ctrl.mem_we;
  assign iord        = r_ctrl.iord;
  assign pc_src      = r_ctrl.pc_src;
  assign reg_write   = r_ctrl.reg_write;
  assign reg_dst     = r_ctrl.reg_dst;
  assign wb_sel      = r_ctrl.wb_sel;
  assign alu_src_b   = r_ctrl.alu_src_b;
  assign alu_op      = r_ctrl.alu_op;
  assign bus_err     = r_ctrl.bus_err;
  assign instr_done  = r_done;
  assign illegal     = r_illegal;
  assign o_dbg_state = r_state;

endmodule
